count_run_ctrl: RTL and testbench

Controller that shares one 2-bit up/down counter between two requesters. Each requester asks for a counting run of a given length and direction. The block arbitrates round-robin, sequences the counter one step per clock for the granted run, and signals completion. It sits in front of the counter datapath and drives Q_A/Q_B as the counter state.

---
 rtl/count_run_ctrl.sv | 113 +++++++++++
 tb/tb_count_run_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_run_ctrl.sv
// count_run_ctrl: shares one 2-bit up/down counter between two requesters.
// An IDLE cycle arbitrates round-robin and latches the winner's direction and
// length. RUN steps the counter once per clock. DONE pulses the owner's Done
// for one cycle, and the block then returns to IDLE.
//
// Handshake: ReqN is a level request sampled only in IDLE. GntN rises one edge
// after the winning request is sampled and stays high through RUN and DONE.
// DoneN is a one-cycle pulse in the last granted cycle. Req/Dir/Len changes
// made while granted are ignored, and a losing request is not queued.
module count_run_ctrl #(
  parameter int LEN_W = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Req0,
  input  logic             Dir0,
  input  logic [LEN_W-1:0] Len0,
  input  logic             Req1,
  input  logic             Dir1,
  input  logic [LEN_W-1:0] Len1,
  output logic             Gnt0,
  output logic             Gnt1,
  output logic             Done0,
  output logic             Done1,
  output logic             Busy,
  output logic             Q_A,
  output logic             Q_B,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [1:0]       cnt, cnt_n;
  logic [LEN_W-1:0] rem, rem_n;
  logic             dir_q, dir_n;
  logic             owner, owner_n;   // requester that owns the current run
  logic             last, last_n;     // requester served most recently
  logic             win;
  logic [LEN_W-1:0] len_sel;

  // State and datapath registers; reset also abandons any run in progress.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= 2'b00;
      rem   <= '0;
      dir_q <= 1'b0;
      owner <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rem   <= rem_n;
      dir_q <= dir_n;
      owner <= owner_n;
      last  <= last_n;
    end
  end

  // Next-state logic: arbitrate in IDLE, step in RUN, release after DONE.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rem_n   = rem;
    dir_n   = dir_q;
    owner_n = owner;
    last_n  = last;
    win     = 1'b0;
    len_sel = '0;
    case (state)
      IDLE: begin
        if (Req0 || Req1) begin
          // On a tie the requester that was not served last wins.
          win     = (Req0 && Req1) ? ~last : Req1;
          len_sel = win ? Len1 : Len0;
          owner_n = win;
          dir_n   = win ? Dir1 : Dir0;
          rem_n   = len_sel;
          state_n = (len_sel != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        cnt_n = dir_q ? (cnt + 2'd1) : (cnt - 2'd1);
        rem_n = rem - LEN_W'(1);
        if (rem == LEN_W'(1)) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
        last_n  = owner;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign Busy      = (state != IDLE);
  assign Gnt0      = Busy & ~owner;
  assign Gnt1      = Busy & owner;
  assign Done0     = (state == DONE) & ~owner;
  assign Done1     = (state == DONE) & owner;
  assign Q_A       = cnt[1];
  assign Q_B       = cnt[0];
  assign state_dbg = state;

endmodule

// File: tb/tb_count_run_ctrl.sv
// Bench for count_run_ctrl: directed scenarios with literal expectations, then
// randomized requests, all checked every cycle against a script-based model.
// Each grant pushes the whole run as a list of future output snapshots.
module tb_count_run_ctrl;

  localparam int LEN_W = 4;

  logic             Clock;
  logic             Reset;
  logic             Req0, Dir0, Req1, Dir1;
  logic [LEN_W-1:0] Len0, Len1;
  logic             Gnt0, Gnt1, Done0, Done1, Busy, Q_A, Q_B;
  logic [1:0]       state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  count_run_ctrl #(.LEN_W(LEN_W)) dut (
    .Clock(Clock), .Reset(Reset),
    .Req0(Req0), .Dir0(Dir0), .Len0(Len0),
    .Req1(Req1), .Dir1(Dir1), .Len1(Len1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Done0(Done0), .Done1(Done1),
    .Busy(Busy), .Q_A(Q_A), .Q_B(Q_B), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    Reset = 1'b0;
    Req0 = 1'b0; Dir0 = 1'b0; Len0 = '0;
    Req1 = 1'b0; Dir1 = 1'b0; Len1 = '0;
  end

  // ---------------- reference model ----------------
  // Snapshot layout: {g0, g1, d0, d1, busy, q[1:0]}
  logic [6:0] exp_q[$];
  logic [6:0] exp_cur;
  logic       m_valid = 1'b0;
  logic       m_last;

  function automatic logic [6:0] snap(input logic g0, input logic g1,
                                      input logic d0, input logic d1,
                                      input logic busy, input logic [1:0] q);
    return {g0, g1, d0, d1, busy, q};
  endfunction

  initial begin : model
    logic             w, dir;
    logic [LEN_W-1:0] len;
    logic [1:0]       q0, q;
    exp_cur = '0;
    m_last  = 1'b1;
    forever begin
      @(posedge Clock);
      if (!Reset) begin
        exp_q.delete();
        m_last  = 1'b1;
        exp_cur = snap(0, 0, 0, 0, 0, 2'b00);
        m_valid = 1'b1;
      end else if (m_valid) begin
        if (exp_q.size() > 0) begin
          exp_cur = exp_q.pop_front();
        end else if (Req0 || Req1) begin
          if (Req0 && Req1) w = (m_last == 1'b1) ? 1'b0 : 1'b1;
          else              w = Req1;
          dir    = w ? Dir1 : Dir0;
          len    = w ? Len1 : Len0;
          m_last = w;
          q0     = exp_cur[1:0];
          q      = q0;
          for (int i = 0; i <= int'(len); i++) begin
            q = dir ? (q0 + 2'(i)) : (q0 - 2'(i));
            if (i == 0)
              exp_cur = snap(~w, w, ~w & (i == int'(len)), w & (i == int'(len)), 1'b1, q);
            else
              exp_q.push_back(snap(~w, w, ~w & (i == int'(len)), w & (i == int'(len)), 1'b1, q));
          end
          exp_q.push_back(snap(0, 0, 0, 0, 0, q));
        end else begin
          exp_cur = snap(0, 0, 0, 0, 0, exp_cur[1:0]);
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge Clock) begin
    if (m_valid) begin
      n_checks++;
      if ({Gnt0, Gnt1, Done0, Done1, Busy, Q_A, Q_B} !== exp_cur) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t got g0g1d0d1bq=%b expected %b", $time,
                 {Gnt0, Gnt1, Done0, Done1, Busy, Q_A, Q_B}, exp_cur);
      end
      n_checks++;
      if ((state_dbg != 2'd0) !== exp_cur[2]) begin
        n_fail++;
        $display("FAIL state_busy t=%0t state_dbg=%0d expected busy=%b", $time,
                 state_dbg, exp_cur[2]);
      end
      n_checks++;
      if ((Gnt0 && Gnt1) || (Done0 && !Gnt0) || (Done1 && !Gnt1)) begin
        n_fail++;
        $display("FAIL exclusivity t=%0t g0=%b g1=%b d0=%b d1=%b required one-hot grant",
                 $time, Gnt0, Gnt1, Done0, Done1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic check_lit(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s t=%0t got %b required %b", name, $time, act, req);
    end
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b0;
    Req0 = 1'b0; Req1 = 1'b0;
    tick(2);
    Reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [1:0] step_q[5];
  logic [3:0] alt_tbl[10];

  initial begin : stim
    // Reset held 2 edges with Req0 high, then a 5-step up run.
    Req0 = 1'b1; Dir0 = 1'b1; Len0 = 4'd5;
    tick(2);
    check_lit("reset_state", {3'b0, Gnt0, Gnt1, Done0, Done1, Busy}, 8'b0);
    check_lit("reset_q", {6'b0, Q_A, Q_B}, 8'b0);
    Reset = 1'b1;
    tick(1);
    check_lit("first_grant", {5'b0, Gnt0, Busy, Done0}, 8'b110);
    Req0 = 1'b0;
    step_q = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check_lit($sformatf("len5_step%0d", i + 1), {5'b0, Q_A, Q_B, Done0},
                {5'b0, step_q[i], (i == 4)});
    end
    tick(1);
    check_lit("len5_release", {4'b0, Gnt0, Busy, Q_A, Q_B}, 8'b0000_0001);

    // Both requesters held: alternation and counter carried across runs.
    do_reset();
    Req0 = 1'b1; Dir0 = 1'b1; Len0 = 4'd2;
    Req1 = 1'b1; Dir1 = 1'b0; Len1 = 4'd3;
    alt_tbl = '{4'b1000, 4'b1001, 4'b1010, 4'b0010, 4'b0110,
                4'b0101, 4'b0100, 4'b0111, 4'b0011, 4'b1011};
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check_lit($sformatf("alt_e%0d", i + 1), {4'b0, Gnt0, Gnt1, Q_A, Q_B},
                {4'b0, alt_tbl[i]});
    end
    Req0 = 1'b0; Req1 = 1'b0;

    // Zero-length run: grant and done together, counter unchanged.
    do_reset();
    Req1 = 1'b1; Dir1 = 1'b0; Len1 = 4'd0;
    tick(1);
    check_lit("len0_grant", {2'b0, Gnt0, Gnt1, Done1, Busy, Q_A, Q_B}, 8'b0001_1100);
    Req1 = 1'b0;
    tick(1);
    check_lit("len0_idle", {4'b0, Gnt1, Done1, Busy, Q_A}, 8'b0);

    // Reset in the middle of a 6-step run.
    do_reset();
    Req0 = 1'b1; Dir0 = 1'b1; Len0 = 4'd6;
    tick(1);
    Req0 = 1'b0;
    tick(2);
    check_lit("abort_pre", {6'b0, Q_A, Q_B}, 8'b0000_0010);
    Reset = 1'b0;
    tick(1);
    check_lit("abort_post", {3'b0, Gnt0, Busy, Done0, Q_A, Q_B}, 8'b0);
    Reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check_lit("abort_no_done", {7'b0, Done0}, 8'b0);
    end

    // Dir/Req changes during a run are ignored.
    do_reset();
    Req0 = 1'b1; Dir0 = 1'b1; Len0 = 4'd4;
    tick(2);
    Dir0 = 1'b0; Req0 = 1'b0;
    tick(3);
    check_lit("ignore_changes", {4'b0, Gnt0, Done0, Q_A, Q_B}, 8'b0000_1100);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clock);
      Reset = ($urandom_range(0, 199) != 0);
      Req0  = ($urandom_range(0, 9) < 6);
      Req1  = ($urandom_range(0, 9) < 6);
      Dir0  = 1'($urandom_range(0, 1));
      Dir1  = 1'($urandom_range(0, 1));
      Len0  = LEN_W'($urandom_range(0, 15));
      Len1  = LEN_W'($urandom_range(0, 15));
    end
    Reset = 1'b1; Req0 = 1'b0; Req1 = 1'b0;
    tick(20);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
